// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory port.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM built from one byte-wide bank per lane; read data is registered.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_reg;

            // Read-before-write: a store's response never uses the read data.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we && be[gi]) begin
                        lane_mem[addr] <= wdata[8*gi +: 8];
                    end
                    rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, commit on entry to RESP.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                we_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic [BE_W-1:0]     be_reg;
    logic                accept;
    logic                commit;

    logic                src_we;
    logic                src_err;
    logic [ADDR_W-1:0]   src_addr;
    logic [WORD_W-1:0]   src_wdata;
    logic [BE_W-1:0]     src_be;
    logic [WORD_W-1:0]   ram_rdata;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^req_addr[WORD_W-1:ADDR_W+2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = LAT_M1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            we_reg    <= req_we;
            err_reg   <= is_misaligned(req_addr);
            addr_reg  <= req_addr[ADDR_W+1:2];
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
        end
    end

    // With LATENCY=1 the commit edge is the accept edge, so the RAM sees the live request.
    assign src_we    = accept ? req_we                     : we_reg;
    assign src_err   = accept ? is_misaligned(req_addr)    : err_reg;
    assign src_addr  = accept ? req_addr[ADDR_W+1:2]       : addr_reg;
    assign src_wdata = accept ? req_wdata                  : wdata_reg;
    assign src_be    = accept ? req_be                     : be_reg;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (commit && !rst),
        .we    (src_we && !src_err),
        .addr  (src_addr),
        .wdata (src_wdata),
        .be    (src_be),
        .rdata (ram_rdata)
    );

    // RAM output register only updates on commit, so it is stable throughout RESP.
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_rdata = (rsp_valid && !we_reg && !err_reg) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed check of dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;
    localparam int LAT4   = 4;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        rst4, req_valid4, req_ready4, req_we4, rsp_valid4, rsp_ready4, rsp_err4;
    logic [31:0] req_addr4, req_wdata4, rsp_rdata4;
    logic [3:0]  req_be4;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [1024];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT4)) dut4 (
        .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_we(req_we4), .req_addr(req_addr4), .req_wdata(req_wdata4), .req_be(req_be4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the LATENCY=2 instance; expectations come from model_mem.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] exp_d;
        logic        exp_e;
        int          idx, g, lat;
        idx   = int'(addr[11:2]);
        exp_e = (addr[1:0] != 2'b00);
        exp_d = 32'h0;
        if (we) begin
            if (!exp_e)
                for (int i = 0; i < 4; i++)
                    if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end else if (!exp_e) begin
            exp_d = model_mem[idx];
        end

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        g = 0;
        while (!req_ready && g < 50) begin tick(); g++; end
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        rsp_ready = 1'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin tick(); lat++; end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = $urandom; req_be = 4'hF;
            check({tag, "_hold_rdata"}, rsp_rdata, exp_d);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            tick();
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        end
        req_valid = 1'b0;
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        tick();
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        $display("xact %s we=%0b addr=%08h wdata=%08h be=%h rdata=%08h err=%0b lat=%0d",
                 tag, we, addr, wdata, be, rd, er, lat);
    endtask

    task automatic xact4(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output int lat);
        int g;
        req_valid4 = 1'b1; req_we4 = we; req_addr4 = addr; req_wdata4 = wdata; req_be4 = 4'hF;
        rsp_ready4 = 1'b1;
        g = 0;
        while (!req_ready4 && g < 50) begin tick(); g++; end
        tick();
        req_valid4 = 1'b0;
        lat = 1;
        while (!rsp_valid4 && lat < 40) begin tick(); lat++; end
        rd = rsp_rdata4;
        tick();
        $display("xact4 we=%0b addr=%08h wdata=%08h rdata=%08h lat=%0d", we, addr, wdata, rd, lat);
    endtask

    initial begin
        logic [31:0] rd, addr;
        logic        er;
        int          lat, seen, idx;

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = $urandom;
        req_be = 4'hF; rsp_ready = 1'b0;
        rst4 = 1'b1; req_valid4 = 1'b0; req_we4 = 1'b0; req_addr4 = 32'h0; req_wdata4 = 32'h0;
        req_be4 = 4'h0; rsp_ready4 = 1'b0;
        repeat (3) tick();
        rst = 1'b0; rst4 = 1'b0; req_valid = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        check("reset_wins_ready", 32'(req_ready), 32'd1);
        check("reset_wins_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 16; i++)
            xact("init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

        xact("st_beef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        xact("ld_beef", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("ld_beef_const", rd, 32'hDEADBEEF);

        xact("st_word20", 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
        xact("st_lanes", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, rd, er);
        xact("ld_lanes", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("ld_lanes_const", rd, 32'h11BB33DD);

        xact("st_misal", 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, rd, er);
        check("st_misal_err", 32'(er), 32'd1);
        xact("ld_after_misal", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("ld_after_misal_const", rd, 32'h11BB33DD);

        xact("ld_backpressure", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);

        xact("st_wrap", 1'b1, 32'h1000, 32'h1, 4'hF, 0, rd, er);
        xact("ld_wrap", 1'b0, 32'h0000, 32'h0, 4'h0, 0, rd, er);
        check("ld_wrap_const", rd, 32'h00000001);

        xact("st_be0", 1'b1, 32'h10, 32'h12345678, 4'h0, 0, rd, er);
        check("st_be0_err", 32'(er), 32'd0);
        xact("ld_be0", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("ld_be0_const", rd, 32'hDEADBEEF);

        for (int n = 0; n < 40; n++) begin
            idx  = $urandom_range(0, 15);
            addr = ($urandom & 32'hFFFF_F000) | 32'(idx << 2);
            if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            xact("rand", 1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
        end

        xact4(1'b1, 32'h40, 32'h0, rd, lat);
        check("l4_store_lat", 32'(lat), 32'(LAT4));
        req_valid4 = 1'b1; req_we4 = 1'b1; req_addr4 = 32'h40; req_wdata4 = 32'h55; req_be4 = 4'hF;
        rsp_ready4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("l4_rst_ready", 32'(req_ready4), 32'd1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid4) seen = 1;
            tick();
        end
        check("l4_rst_no_rsp", 32'(seen), 32'd0);
        xact4(1'b0, 32'h40, 32'h0, rd, lat);
        check("l4_load_lat", 32'(lat), 32'(LAT4));
        check("l4_load_dropped_store", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
